// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequenced ALU block.
// Holds the opcode encodings, the FSM state encoding and the bit positions of
// the {cf, of, zf} flag vector used by alu_core and alu_seq.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  localparam int unsigned FLAG_CF = 2;
  localparam int unsigned FLAG_OF = 1;
  localparam int unsigned FLAG_ZF = 0;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StResp = 2'b10
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational 4-bit ALU.
// Ports:
//   a, b : operands
//   s    : opcode (see alu_seq_pkg)
//   y    : result
//   cf   : carry (add) / borrow (sub), 0 for logic ops
//   of   : signed overflow (add/sub), 0 for logic ops
//   zf   : result is zero
// Undefined opcodes yield y = 0 with cf = of = 0, so zf = 1.
module alu_core
  import alu_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] s,
  output logic [3:0] y,
  output logic       cf,
  output logic       of,
  output logic       zf
);

  logic [4:0] sum;
  logic [4:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Bit 4 of the zero-extended difference is set exactly when a < b.
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    y  = 4'h0;
    cf = 1'b0;
    of = 1'b0;
    case (s)
      OP_ADD: begin
        y  = sum[3:0];
        cf = sum[4];
        of = (a[3] == b[3]) && (sum[3] != a[3]);
      end
      OP_SUB: begin
        y  = diff[3:0];
        cf = diff[4];
        of = (a[3] != b[3]) && (diff[3] != a[3]);
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      default: y = 4'h0;
    endcase
  end

  assign zf = (y == 4'h0);

endmodule

// File: rtl/alu_seq.sv
// Sequenced ALU with a 4 x 4-bit register file and a {cf, of, zf} flag register.
// A command is accepted in IDLE, executed for exactly one cycle in EXEC and its
// response is held in RESP until the consumer takes it.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   cmd_valid / cmd_ready       : command handshake (ready only in IDLE)
//   cmd_op, cmd_ld, cmd_imm     : ALU opcode, load-immediate select, immediate
//   cmd_ra, cmd_rb, cmd_rd      : source A, source B, destination index
//   cmd_we                      : write result to cmd_rd
//   rsp_valid / rsp_ready       : response handshake
//   rsp_y, rsp_flags            : result and {cf, of, zf} after the command
//   dbg_addr / dbg_data         : combinational register-file read port
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic       cmd_ld,
  input  logic [3:0] cmd_imm,
  input  logic [1:0] cmd_ra,
  input  logic [1:0] cmd_rb,
  input  logic [1:0] cmd_rd,
  input  logic       cmd_we,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_y,
  output logic [2:0] rsp_flags,
  input  logic [1:0] dbg_addr,
  output logic [3:0] dbg_data
);

  state_e state_q, state_d;

  logic [3:0] rf_q [4];
  logic [3:0] rf_d [4];
  logic [2:0] flags_q, flags_d;

  // Command latched at accept; operand values are captured then, not in EXEC.
  logic [2:0] op_q, op_d;
  logic       ld_q, ld_d;
  logic [3:0] imm_q, imm_d;
  logic [1:0] rd_q, rd_d;
  logic       we_q, we_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;

  logic [3:0] rsp_y_q, rsp_y_d;
  logic [2:0] rsp_flags_q, rsp_flags_d;

  logic [3:0] alu_y;
  logic       alu_cf, alu_of, alu_zf;
  logic [2:0] alu_flags;
  logic [3:0] res_y;
  logic [2:0] res_flags;
  logic       accept;

  alu_core u_alu_core (
    .a  (a_q),
    .b  (b_q),
    .s  (op_q),
    .y  (alu_y),
    .cf (alu_cf),
    .of (alu_of),
    .zf (alu_zf)
  );

  always_comb begin
    alu_flags          = 3'b000;
    alu_flags[FLAG_CF] = alu_cf;
    alu_flags[FLAG_OF] = alu_of;
    alu_flags[FLAG_ZF] = alu_zf;
  end

  // Loads report the current flag register and leave it untouched.
  assign res_y     = ld_q ? imm_q : alu_y;
  assign res_flags = ld_q ? flags_q : alu_flags;

  assign cmd_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_y     = rsp_y_q;
  assign rsp_flags = rsp_flags_q;
  assign dbg_data  = rf_q[dbg_addr];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cmd_valid) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    op_d        = op_q;
    ld_d        = ld_q;
    imm_d       = imm_q;
    rd_d        = rd_q;
    we_d        = we_q;
    a_d         = a_q;
    b_d         = b_q;
    rf_d        = rf_q;
    flags_d     = flags_q;
    rsp_y_d     = rsp_y_q;
    rsp_flags_d = rsp_flags_q;

    if (accept) begin
      op_d  = cmd_op;
      ld_d  = cmd_ld;
      imm_d = cmd_imm;
      rd_d  = cmd_rd;
      we_d  = cmd_we;
      a_d   = rf_q[cmd_ra];
      b_d   = rf_q[cmd_rb];
    end

    if (state_q == StExec) begin
      rsp_y_d     = res_y;
      rsp_flags_d = res_flags;
      if (we_q) rf_d[rd_q] = res_y;
      if (!ld_q) flags_d = alu_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= 3'b000;
      ld_q        <= 1'b0;
      imm_q       <= 4'h0;
      rd_q        <= 2'b00;
      we_q        <= 1'b0;
      a_q         <= 4'h0;
      b_q         <= 4'h0;
      flags_q     <= 3'b000;
      rsp_y_q     <= 4'h0;
      rsp_flags_q <= 3'b000;
      for (int i = 0; i < 4; i++) rf_q[i] <= 4'h0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ld_q        <= ld_d;
      imm_q       <= imm_d;
      rd_q        <= rd_d;
      we_q        <= we_d;
      a_q         <= a_d;
      b_q         <= b_d;
      flags_q     <= flags_d;
      rsp_y_q     <= rsp_y_d;
      rsp_flags_q <= rsp_flags_d;
      for (int i = 0; i < 4; i++) rf_q[i] <= rf_d[i];
    end
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block accepts a command this cycle.
REQ-006 cmd_op  input  3  ALU opcode: 000 add, 001 sub, 100 and, 101 or, 110 xor, 111 not-a, others undefined.
REQ-007 cmd_ld  input  1  1 = load immediate, 0 = ALU operation.
REQ-008 cmd_imm  input  4  immediate for load.
REQ-009 cmd_ra, cmd_rb, cmd_rd  input  2 each  source A, source B, destination register index.
REQ-010 cmd_we  input  1  write result to rd.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  consumer takes response.
REQ-013 rsp_y  output  4  result.
REQ-014 rsp_flags  output  3  {cf, of, zf} after the command.
REQ-015 dbg_addr  input  2 / dbg_data  output  4  combinational register-file read port.

Function
REQ-016 Register file: 4 x 4-bit registers; flag register: 3 bits {cf, of, zf}.
REQ-017 FSM states: IDLE, EXEC, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-018 Accept = cmd_valid & cmd_ready at a rising edge: latch op, ld, imm, rd, we, and values reg[ra], reg[rb]; go to EXEC.
REQ-019 ra = rb SHALL be legal; both operands get the same register value.
REQ-020 EXEC lasts exactly one cycle; at its closing edge: latch rsp_y and rsp_flags, write reg[rd] if we, update flag register (ALU ops only); go to RESP.
REQ-021 Latency: command accepted at edge N -> rsp_valid = 1 after edge N+1.
REQ-022 RESP holds rsp_valid, rsp_y and rsp_flags stable until rsp_valid & rsp_ready at an edge, then IDLE.
REQ-023 Minimum spacing between accepts: 3 cycles with rsp_ready held at 1.
REQ-024 Add: y = (a+b) mod 16; cf = carry out; of = signed overflow.
REQ-025 Sub: y = (a-b) mod 16; cf = borrow (1 iff a < b unsigned); of = signed overflow.
REQ-026 Logic ops: and, or, xor, not-a (y = ~a); cf = 0, of = 0.
REQ-027 Every ALU op: zf = (y == 0).
REQ-028 Undefined opcodes (010, 011): y = 0, cf = 0, of = 0, zf = 1; write back and flag update SHALL still apply.
REQ-029 Load: y = imm; reg[rd] written if we; flag register unchanged; rsp_flags = current flag register.
REQ-030 A command SHALL read register values that include every write from all previously completed commands.
REQ-031 cmd_* inputs SHALL be ignored outside IDLE.
REQ-032 dbg_data = reg[dbg_addr] combinationally, showing a write from the cycle after its edge.

Reset
REQ-033 rst_n low SHALL immediately set: state IDLE, all registers 0, flags 000, rsp_valid 0, rsp_y 0, rsp_flags 000.
REQ-034 cmd_ready SHALL be 1 during reset and on the first cycle after it.
REQ-035 Reset in EXEC or RESP SHALL abort the command with no write back and no response.

Structure
REQ-036 A shared package SHALL hold: opcode constants (OP_ADD 000, OP_SUB 001, OP_AND 100, OP_OR 101, OP_XOR 110, OP_NOT 111); FSM state encoding; flag bit positions (CF 2, OF 1, ZF 0).
REQ-037 The combinational 4-bit ALU SHALL be one sub-module, alu_core: inputs a, b, s; outputs y, cf, of, zf; behaviour per REQ-024 to REQ-028.
REQ-038 The rest SHALL be alu_seq: FSM, register file, response registers.

Verification
REQ-039 Load r0 = 7, load r1 = 1, then add rd = r2 with ra = r0, rb = r1 -> rsp_y = 8, flags {0,1,0}; dbg r2 = 8.
REQ-040 r0 = 0, r1 = 1, sub r0 - r1 -> rsp_y = F, flags {1,0,0}; then 8 - 1 -> y = 7, flags {0,1,0}.
REQ-041 r0 = F, r1 = 1, add with we = 0 -> y = 0, flags {1,0,1}; r-file unchanged; a following load reports {1,0,1}.
REQ-042 Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid, rsp_y and rsp_flags stable; cmd_ready = 0; cmd_valid pulses ignored.
REQ-043 Opcode 010 -> y = 0, flags {0,0,1}; xor of A and 5 -> y = F.
REQ-044 Assert rst_n = 0 during EXEC of add to r3 -> no response; r3 = 0; cmd_ready = 1 after release.
